countdown_ctrl: RTL and testbench
=================================

// Module: countdown_ctrl
// PURPOSE
//   Controller that drives the BCD down-counter digit chain. Clears and loads
//   the chain from the user switches, generates the one-cycle count tick into
//   the least-significant digit and stops on chain terminal count. Start/pause/
//   load commands come from debounced buttons; status goes to the display logic.
// PARAMETERS
//   CLK_HZ   50_000_000  system clock frequency
//   TICK_HZ  1           count rate; PRESCALE = CLK_HZ/TICK_HZ, must be >= 2
// PORTS
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active-high
//   start_btn    in   1  debounced level; rising edge = start/resume
//   pause_btn    in   1  debounced level; rising edge = pause/resume toggle
//   load_btn     in   1  debounced level; rising edge = clear + reload digits
//   digits_zero  in   1  all digit displays read 0
//   done_in      in   1  DNB output of most-significant digit (chain expired)
//   digit_rst_n  out  1  active-low reset to the digit chain
//   reconfig     out  1  one-cycle load strobe to all digits
//   tick         out  1  one-cycle count enable to least-significant digit
//   running      out  1  high in RUN
//   expired      out  1  high in EXPIRED
//   state        out  3  current state encoding (debug/LCD)
// BEHAVIOUR
//   Reset: state=IDLE, digit_rst_n=0, reconfig=0, tick=0, running=0,
//     expired=0, prescaler=0; button edge registers reset to 1, so a button
//     held through reset does not fire after release. digit_rst_n=1 from the
//     first cycle after rst deasserts, except in CLR.
//   Edge detect: cmd = btn & ~btn_q, one-cycle pulse per press.
//   States: IDLE=0 CLR=1 LOAD=2 ARMED=3 RUN=4 PAUSED=5 EXPIRED=6.
//   IDLE:    load -> CLR. start/pause ignored.
//   CLR:     digit_rst_n=0 for exactly 1 cycle (returns digits to load
//            state) -> LOAD unconditionally.
//   LOAD:    reconfig=1 for exactly 1 cycle -> ARMED unconditionally.
//   ARMED:   load -> CLR; start and digits_zero=1 -> EXPIRED (zero ticks);
//            start and digits_zero=0 -> RUN with prescaler=0.
//   RUN:     prescaler counts 0..PRESCALE-1 and wraps to 0; tick=1 on the
//            cycle after the count value PRESCALE-1 (first tick PRESCALE
//            cycles after entering RUN). done_in -> EXPIRED; load -> CLR;
//            pause -> PAUSED. start ignored.
//   PAUSED:  prescaler holds; pause or start -> RUN, prescaler resumes from
//            held value; load -> CLR.
//   EXPIRED: expired=1, tick never asserted; load -> CLR; others ignored.
//   Priority in one cycle: done_in > load > pause > start. done_in sampled
//     only in RUN.
//   tick is suppressed if RUN is exited in the cycle the prescaler hits
//     PRESCALE-1 (no tick after pause/done/load).
//   Prescaler width $clog2(PRESCALE); cleared on CLR, ARMED->RUN, reset.
//   running/expired/state registered, updated with state.
//   rst mid-operation: returns to reset values next cycle regardless of state.
// TESTING (CLK_HZ=4, TICK_HZ=1 -> PRESCALE=4)
//   rst=1 3 cycles with load_btn=1, release -> IDLE, all outs 0, no CLR
//     entry until load_btn toggles 0->1.
//   load edge in IDLE -> next cycle digit_rst_n=0 (CLR), next reconfig=1
//     (LOAD), next state=3 ARMED; each strobe exactly 1 cycle.
//   ARMED, start edge, digits_zero=0 -> running=1; tick at cycles 4,8,12
//     after RUN entry, each 1 cycle wide.
//   RUN 2 cycles, pause edge, hold 10 cycles, start edge -> no tick while
//     PAUSED; next tick 2 cycles after re-entering RUN.
//   done_in=1 with pause edge in same cycle -> EXPIRED, expired=1, running=0,
//     no further ticks; load edge then -> CLR.
//   ARMED with digits_zero=1, start edge -> EXPIRED next cycle, zero ticks.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Countdown controller: sequences clear/load of the BCD digit chain and paces the count tick.
// Latency: commands act on the cycle after the button edge; outputs are registered with state.
// No backpressure: button edges are one-shot and any edge that the current state ignores is dropped.
module countdown_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       load_btn,
  input  logic       digits_zero,
  input  logic       done_in,
  output logic       digit_rst_n,
  output logic       reconfig,
  output logic       tick,
  output logic       running,
  output logic       expired,
  output logic [2:0] state
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_ARMED   = 3'd3,
    ST_RUN     = 3'd4,
    ST_PAUSED  = 3'd5,
    ST_EXPIRED = 3'd6
  } state_t;

  state_t        cur;
  state_t        nxt;
  logic          start_q;
  logic          pause_q;
  logic          load_q;
  logic          start_cmd;
  logic          pause_cmd;
  logic          load_cmd;
  logic [PW-1:0] prescaler;
  logic          digit_rst_n_d;
  logic          reconfig_d;
  logic          tick_d;
  logic          running_d;
  logic          expired_d;

  // Edge registers start at 1 so a button held through reset cannot fire on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b1;
      pause_q <= 1'b1;
      load_q  <= 1'b1;
    end else begin
      start_q <= start_btn;
      pause_q <= pause_btn;
      load_q  <= load_btn;
    end
  end

  assign start_cmd = start_btn & ~start_q;
  assign pause_cmd = pause_btn & ~pause_q;
  assign load_cmd  = load_btn  & ~load_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= ST_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // Next-state decode; order of tests gives done_in > load > pause > start.
  always_comb begin
    nxt = cur;
    unique case (cur)
      ST_IDLE:    if (load_cmd) nxt = ST_CLR;
      ST_CLR:     nxt = ST_LOAD;
      ST_LOAD:    nxt = ST_ARMED;
      ST_ARMED: begin
        if (load_cmd)       nxt = ST_CLR;
        else if (start_cmd) nxt = digits_zero ? ST_EXPIRED : ST_RUN;
      end
      ST_RUN: begin
        if (done_in)        nxt = ST_EXPIRED;
        else if (load_cmd)  nxt = ST_CLR;
        else if (pause_cmd) nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (load_cmd)                    nxt = ST_CLR;
        else if (pause_cmd || start_cmd) nxt = ST_RUN;
      end
      ST_EXPIRED: if (load_cmd) nxt = ST_CLR;
      default:    nxt = ST_IDLE;
    endcase
  end

  // Prescaler advances every RUN cycle, holds when paused, clears on CLR and on arming into RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
    end else if (cur == ST_CLR || (cur == ST_ARMED && nxt == ST_RUN)) begin
      prescaler <= '0;
    end else if (cur == ST_RUN) begin
      prescaler <= (prescaler == PS_MAX) ? '0 : prescaler + 1'b1;
    end
  end

  // Output decode from the state being entered; tick only if RUN is kept across the wrap.
  always_comb begin
    digit_rst_n_d = (nxt != ST_CLR);
    reconfig_d    = (nxt == ST_LOAD);
    running_d     = (nxt == ST_RUN);
    expired_d     = (nxt == ST_EXPIRED);
    tick_d        = (cur == ST_RUN) && (nxt == ST_RUN) && (prescaler == PS_MAX);
  end

  // Output registers, updated together with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_rst_n <= 1'b0;
      reconfig    <= 1'b0;
      tick        <= 1'b0;
      running     <= 1'b0;
      expired     <= 1'b0;
    end else begin
      digit_rst_n <= digit_rst_n_d;
      reconfig    <= reconfig_d;
      tick        <= tick_d;
      running     <= running_d;
      expired     <= expired_d;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios followed by random button traffic.
// Every cycle all outputs are compared against a reference model.
// The model tracks RUN time as a plain cycle count and derives ticks with modulo arithmetic.
module tb_countdown_ctrl;

  localparam int P = 4;

  localparam int IDLE = 0, CLR = 1, LOAD = 2, ARMED = 3, RUN = 4, PAUSED = 5, EXP = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       load_btn = 1'b0;
  logic       digits_zero = 1'b0;
  logic       done_in = 1'b0;
  logic       digit_rst_n;
  logic       reconfig;
  logic       tick;
  logic       running;
  logic       expired;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int m_state = IDLE;
  int m_run_cycles = 0;
  bit m_tick = 0;
  bit m_rstn = 0;
  bit m_reconf = 0;
  bit m_sp = 1, m_pp = 1, m_lp = 1;

  countdown_ctrl #(.CLK_HZ(4), .TICK_HZ(1)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .load_btn(load_btn), .digits_zero(digits_zero), .done_in(done_in),
    .digit_rst_n(digit_rst_n), .reconfig(reconfig), .tick(tick),
    .running(running), .expired(expired), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT sees at this edge.
  task automatic model_edge();
    int  nx;
    bit  s_e, p_e, l_e;
    if (rst) begin
      m_state = IDLE; m_run_cycles = 0; m_tick = 0; m_rstn = 0; m_reconf = 0;
      m_sp = 1; m_pp = 1; m_lp = 1;
      return;
    end
    s_e = start_btn && !m_sp;
    p_e = pause_btn && !m_pp;
    l_e = load_btn  && !m_lp;
    nx = m_state;
    case (m_state)
      IDLE:   if (l_e) nx = CLR;
      CLR:    nx = LOAD;
      LOAD:   nx = ARMED;
      ARMED:  if (l_e) nx = CLR; else if (s_e) nx = digits_zero ? EXP : RUN;
      RUN:    if (done_in) nx = EXP; else if (l_e) nx = CLR; else if (p_e) nx = PAUSED;
      PAUSED: if (l_e) nx = CLR; else if (p_e || s_e) nx = RUN;
      EXP:    if (l_e) nx = CLR;
      default: nx = IDLE;
    endcase
    // a tick lands on every PRESCALE-th RUN cycle, but only if RUN is kept
    m_tick = (m_state == RUN) && (nx == RUN) && (m_run_cycles % P == P - 1);
    if (m_state == CLR || (m_state == ARMED && nx == RUN)) m_run_cycles = 0;
    else if (m_state == RUN) m_run_cycles++;
    m_sp = start_btn; m_pp = pause_btn; m_lp = load_btn;
    m_state  = nx;
    m_rstn   = (nx != CLR);
    m_reconf = (nx == LOAD);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("state",       32'(state),       32'(m_state));
      chk("running",     32'(running),     32'(m_state == RUN));
      chk("expired",     32'(expired),     32'(m_state == EXP));
      chk("tick",        32'(tick),        32'(m_tick));
      chk("digit_rst_n", 32'(digit_rst_n), 32'(m_rstn));
      chk("reconfig",    32'(reconfig),    32'(m_reconf));
    end
  endtask

  initial begin
    // reset with load held: must not start a clear after release
    rst = 1; load_btn = 1;
    step(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rstn",  32'(digit_rst_n), 32'd0);
    rst = 0;
    step(3);
    chk("held_load_idle", 32'(state), 32'd0);
    chk("post_rst_rstn",  32'(digit_rst_n), 32'd1);

    // load edge: CLR, LOAD, ARMED each one cycle
    load_btn = 0; step(1);
    load_btn = 1; step(1);
    chk("clr_rstn", 32'(digit_rst_n), 32'd0);
    step(1);
    chk("load_reconfig", 32'(reconfig), 32'd1);
    chk("load_rstn_back", 32'(digit_rst_n), 32'd1);
    step(1);
    chk("armed_state", 32'(state), 32'd3);
    chk("reconfig_1cyc", 32'(reconfig), 32'd0);
    load_btn = 0;

    // start: ticks on cycles 4, 8, 12 of RUN
    digits_zero = 0; start_btn = 1; step(1);
    chk("run_running", 32'(running), 32'd1);
    start_btn = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk("run_tick_pos", 32'(tick), 32'(i % 4 == 0));
    end

    // one more RUN cycle, pause, hold, resume: tick 2 cycles after resume
    step(1);
    pause_btn = 1; step(1);
    chk("paused_state", 32'(state), 32'd5);
    pause_btn = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("paused_no_tick", 32'(tick), 32'd0);
    end
    start_btn = 1; step(1);
    chk("resume_running", 32'(running), 32'd1);
    start_btn = 0;
    step(1);
    chk("resume_tick_early", 32'(tick), 32'd0);
    step(1);
    chk("resume_tick", 32'(tick), 32'd1);

    // done_in wins over a simultaneous pause edge
    done_in = 1; pause_btn = 1; step(1);
    chk("done_expired", 32'(expired), 32'd1);
    chk("done_not_running", 32'(running), 32'd0);
    done_in = 0; pause_btn = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("expired_no_tick", 32'(tick), 32'd0);
    end
    load_btn = 1; step(1);
    chk("expired_load_clr", 32'(state), 32'd1);
    load_btn = 0;
    step(2);

    // zero digits: start goes straight to EXPIRED
    digits_zero = 1; start_btn = 1; step(1);
    chk("zero_expired", 32'(state), 32'd6);
    start_btn = 0; digits_zero = 0;
    step(4);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0)  start_btn = ~start_btn;
      if ($urandom_range(0, 9) == 0)  pause_btn = ~pause_btn;
      if ($urandom_range(0, 19) == 0) load_btn = ~load_btn;
      done_in     = ($urandom_range(0, 29) == 0);
      digits_zero = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
